leaf_stream_packetizer: RTL and testbench
=========================================

// Module: leaf_stream_packetizer
// PURPOSE
//  Transmit end of the page-to-BFT leaf link: accepts a 32-bit user AXI-stream from an
//  HLS kernel output and emits 49-bit BFT packets toward a fixed destination leaf/port.
//  Uses credit-based flow control against the receiving leaf's input BRAM.
//  Credits are replenished by freespace-update packets arriving from the BFT.
//  Sits inside a page wrapper between the user kernel and the BFT leaf port.
// PARAMETERS
//  PACKET_BITS         49   packet width = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
//  PAYLOAD_BITS        32   user data width
//  NUM_LEAF_BITS       5    destination leaf field width
//  NUM_PORT_BITS       4    destination port field width
//  NUM_ADDR_BITS       7    write-address field width; wraps modulo 2^NUM_ADDR_BITS
//  NUM_BRAM_ADDR_BITS  7    remote buffer depth = 2^NUM_BRAM_ADDR_BITS = reset/max credits
//  CREDIT_PORT         0    port-field value identifying an incoming freespace-update packet
//  FIFO_DEPTH          4    input skid FIFO depth (power of 2, >= 2)
// PORTS
//  ap_clk                   in   1    clock
//  ap_rst_n                 in   1    asynchronous active-low reset
//  dest_leaf                in   5    destination leaf; sampled on every packet, hold static
//  dest_port                in   4    destination port; sampled on every packet, hold static
//  Input_1_V_TDATA          in   32   user payload
//  Input_1_V_TVALID         in   1    payload valid
//  Input_1_V_TREADY         out  1    packetizer can accept payload
//  din_leaf_bft2interface   in   49   packets from BFT (credit returns)
//  dout_leaf_interface2bft  out  49   packets to BFT
//  credits                  out  8    current credit count, 0..2^NUM_BRAM_ADDR_BITS
//  pkt_count                out  16   packets sent since reset; wraps at 2^16
// BEHAVIOUR
//  Packet fields: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
//  Reset (ap_rst_n=0, async): dout=0, TREADY=0, FIFO empty, addr=0,
//   credits=2^NUM_BRAM_ADDR_BITS (128), pkt_count=0.
//  TREADY is registered: it is 1 in the first clock after reset release, and is
//   thereafter 1 iff FIFO occupancy after this edge < FIFO_DEPTH. A word is accepted
//   iff TVALID & TREADY at the rising edge; no word is ever dropped or duplicated.
//  States: RUN, NOCRED.
//   RUN: if FIFO non-empty and credits>0, pop the head word and register
//    dout={1,dest_leaf,dest_port,addr,word}; then addr+=1, credits-=1, pkt_count+=1.
//    Go to NOCRED when credits reaches 0 after the send.
//   NOCRED: dout valid=0, nothing is popped; return to RUN when credits>0.
//  An idle dout cycle drives all 49 bits to 0.
//  Latency: a word accepted at edge N, with empty FIFO and credits>0, appears on dout
//   after edge N+2. Back-to-back throughput is 1 packet/cycle.
//  Credit return: when din[48]=1 and din[42:39]==CREDIT_PORT,
//   credits += din[NUM_BRAM_ADDR_BITS:0]. Other valid din packets are ignored.
//  A send and a credit return in the same cycle are both applied:
//   credits_next = credits - send + ret.
//  The result saturates at 2^NUM_BRAM_ADDR_BITS. The block never underflows and never
//   emits a packet when credits=0.
//  addr wraps 127 -> 0 without a stall. pkt_count wraps 0xFFFF -> 0.
//  Full FIFO with a simultaneous pop and push: both occur, and occupancy is unchanged.
//  Reset mid-burst: FIFO contents are discarded, dout is forced to 0 immediately
//   (async), and credits are restored to 128.
// TESTING
//  1. Reset, dest=leaf 3/port 2, push 0xA5A5_0001 -> dout=0x1_1900_A5A5_0001
//     (the {1,3,2,0,word} encoding) after 2 cycles, with credits=127 and pkt_count=1.
//  2. Stream 200 words with no credit returns -> exactly 128 packets, addr 0..127,
//     then NOCRED with TREADY=0 once the FIFO holds 4 words; dout valid stays 0.
//  3. From the step-2 stall, inject a credit packet (port 0, payload 16) -> 16 more
//     packets with addr 0..15, then stall again.
//  4. Send and credit return of 1 in the same cycle at credits=128 -> credits stays 128
//     (saturation); at credits=1 -> stays 1.
//  5. Random TVALID at 50% with random credit returns of 1..8, 10k words -> scoreboard
//     matches payload order, addr increments mod 128, credits never exceed 128.
//  6. Assert ap_rst_n low mid-burst for 3 cycles -> dout=0 immediately, after release
//     TREADY=1, credits=128, addr restarts at 0.

Source files
------------

// File: rtl/leaf_stream_packetizer.sv
// Credit-flow-controlled packetizer: wraps a 32-bit user stream into BFT packets
// addressed to a fixed leaf/port, throttled by freespace credits from the receiver.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 5,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_ADDR_BITS      = 7,
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter int CREDIT_PORT        = 0,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dest_port,
    input  logic [PAYLOAD_BITS-1:0]       Input_1_V_TDATA,
    input  logic                          Input_1_V_TVALID,
    output logic                          Input_1_V_TREADY,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    output logic [NUM_BRAM_ADDR_BITS:0]   credits,
    output logic [15:0]                   pkt_count
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int CRED_W    = NUM_BRAM_ADDR_BITS + 1;
    localparam int CW1       = CRED_W + 1;
    localparam int ADDR_LO   = PAYLOAD_BITS;
    localparam int PORT_LO   = ADDR_LO + NUM_ADDR_BITS;
    localparam int LEAF_LO   = PORT_LO + NUM_PORT_BITS;
    localparam int VALID_BIT = PACKET_BITS - 1;

    localparam logic [CNT_W-1:0]         DEPTH_V    = CNT_W'(FIFO_DEPTH);
    localparam logic [CW1-1:0]           MAX_CRED   = CW1'(1) << NUM_BRAM_ADDR_BITS;
    localparam logic [NUM_PORT_BITS-1:0] CRED_PORT  = NUM_PORT_BITS'(CREDIT_PORT);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_NOCRED = 1'b1;

    logic [PAYLOAD_BITS-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_tready;
    logic [0:0]               r_state;
    logic [CRED_W-1:0]        r_credits;
    logic [NUM_ADDR_BITS-1:0] r_addr;
    logic [15:0]              r_pkt_count;
    logic [PACKET_BITS-1:0]   r_stage;
    logic [PACKET_BITS-1:0]   r_dout;

    logic                     w_push;
    logic                     w_pop;
    logic [PAYLOAD_BITS-1:0]  w_head;
    logic [CNT_W-1:0]         w_count_next;
    logic                     w_is_credit;
    logic [CW1-1:0]           w_ret;
    logic [CW1-1:0]           w_cred_sum;
    logic [CRED_W-1:0]        w_credits_next;
    logic [0:0]               w_state_next;
    logic                     w_unused_din;

    assign w_push       = Input_1_V_TVALID && r_tready;
    assign w_pop        = (r_state == S_RUN) && (r_count != '0) && (r_credits != '0);
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_is_credit  = din_leaf_bft2interface[VALID_BIT] &&
                          (din_leaf_bft2interface[LEAF_LO-1:PORT_LO] == CRED_PORT);
    assign w_ret        = w_is_credit ? CW1'(din_leaf_bft2interface[NUM_BRAM_ADDR_BITS:0]) : '0;
    // One extra bit of headroom so a large return cannot wrap before saturation.
    assign w_cred_sum   = CW1'(r_credits) - CW1'(w_pop) + w_ret;
    assign w_credits_next = (w_cred_sum > MAX_CRED) ? MAX_CRED[CRED_W-1:0] : w_cred_sum[CRED_W-1:0];

    assign w_unused_din = ^{din_leaf_bft2interface[VALID_BIT-1:LEAF_LO],
                            din_leaf_bft2interface[PORT_LO-1:CRED_W]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (w_credits_next == '0) w_state_next = S_NOCRED;
            S_NOCRED: if (w_credits_next != '0) w_state_next = S_RUN;
            default:  w_state_next = S_RUN;
        endcase
    end

    // Storage has no reset so it can map onto plain RAM; occupancy lives in r_count.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= Input_1_V_TDATA;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tready    <= 1'b0;
            r_state     <= S_RUN;
            r_credits   <= MAX_CRED[CRED_W-1:0];
            r_addr      <= '0;
            r_pkt_count <= '0;
            r_stage     <= '0;
            r_dout      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_addr      <= r_addr + NUM_ADDR_BITS'(1);
                r_pkt_count <= r_pkt_count + 16'd1;
                r_stage     <= {1'b1, dest_leaf, dest_port, r_addr, w_head};
            end else begin
                r_stage     <= '0;
            end
            r_count   <= w_count_next;
            r_tready  <= (w_count_next < DEPTH_V);
            r_credits <= w_credits_next;
            r_state   <= w_state_next;
            r_dout    <= r_stage;
        end
    end

    assign Input_1_V_TREADY        = r_tready;
    assign dout_leaf_interface2bft = r_dout;
    assign credits                 = r_credits;
    assign pkt_count               = r_pkt_count;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: queue-based reference model compared every cycle,
// plus directed literal checks for encoding, credit stall/refill, saturation and reset.
module tb_leaf_stream_packetizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  dest_leaf = '0;
    logic [3:0]  dest_port = '0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [48:0] din = '0;
    logic [48:0] dout;
    logic [7:0]  credits;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    leaf_stream_packetizer dut (
        .ap_clk                  (clk),
        .ap_rst_n                (rst_n),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .Input_1_V_TDATA         (tdata),
        .Input_1_V_TVALID        (tvalid),
        .Input_1_V_TREADY        (tready),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .credits                 (credits),
        .pkt_count               (pkt_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] cred_pkt(input int n);
        return {1'b1, 5'd0, 4'd0, 7'd0, 32'(n)};
    endfunction

    // Reference model: FIFO as a queue, credits as a saturating integer,
    // outputs appear two edges after acceptance.
    int unsigned m_q[$];
    int          m_credits = 128;
    int          m_addr = 0;
    int          m_pkt = 0;
    bit          m_tready = 1'b0;
    logic [48:0] m_stage = '0;
    logic [48:0] m_dout = '0;

    always @(posedge clk or negedge rst_n) begin
        bit          send;
        bit          push;
        int          ret;
        logic [31:0] w;
        if (!rst_n) begin
            m_q.delete();
            m_credits = 128;
            m_addr    = 0;
            m_pkt     = 0;
            m_tready  = 1'b0;
            m_stage   = '0;
            m_dout    = '0;
        end else begin
            send = (m_q.size() > 0) && (m_credits > 0);
            push = tvalid && m_tready;
            ret  = (din[48] && din[42:39] == 4'd0) ? int'(din[7:0]) : 0;
            m_dout = m_stage;
            if (send) begin
                w       = m_q.pop_front();
                m_stage = {1'b1, dest_leaf, dest_port, 7'(m_addr), w};
                m_addr  = (m_addr + 1) % 128;
                m_pkt   = (m_pkt + 1) % 65536;
            end else begin
                m_stage = '0;
            end
            if (push) m_q.push_back(tdata);
            m_credits = m_credits - int'(send) + ret;
            if (m_credits > 128) m_credits = 128;
            m_tready = (m_q.size() < 4);
        end
    end

    int win_cnt = 0;
    int win_first = -1;
    int win_last = -1;

    always @(negedge clk) begin
        chk("dout", 64'(dout), 64'(m_dout));
        chk("tready", 64'(tready), 64'(m_tready));
        chk("credits", 64'(credits), 64'(m_credits));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("credit_le_128", 64'(credits <= 8'd128), 64'd1);
        if (dout[48] === 1'b1) begin
            if (win_cnt == 0) win_first = int'(dout[38:32]);
            win_last = int'(dout[38:32]);
            win_cnt++;
        end
    end

    int word_ctr = 32'h1000;
    int n_acc = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        tvalid = 1'b0;
        din    = '0;
        #1;
        chk("rst_async_dout", 64'(dout), 64'd0);
        chk("rst_async_tready", 64'(tready), 64'd0);
        chk("rst_async_credits", 64'(credits), 64'd128);
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic stream(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            din    = '0;
            tvalid = 1'b1;
            tdata  = 32'(word_ctr);
            if (tready) begin
                word_ctr++;
                n_acc++;
            end
        end
    endtask

    initial begin
        int cyc;
        int r;
        repeat (2) tick();
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_tready", 64'(tready), 64'd0);
        chk("reset_credits", 64'(credits), 64'd128);
        chk("reset_pkt_count", 64'(pkt_count), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("tready_after_release", 64'(tready), 64'd1);

        // Single word: encoding and two-edge latency
        dest_leaf = 5'd3;
        dest_port = 4'd2;
        tvalid = 1'b1;
        tdata  = 32'hA5A5_0001;
        tick();
        tvalid = 1'b0;
        tick();
        chk("t1_not_yet", 64'(dout), 64'd0);
        tick();
        chk("t1_dout", 64'(dout), 64'h1_1900_A5A5_0001);
        chk("t1_credits", 64'(credits), 64'd127);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // Saturation at 128: send plus return of 1, then pure return while full
        do_reset();
        tvalid = 1'b1;
        tdata  = 32'h0000_BEEF;
        tick();
        tvalid = 1'b0;
        din    = cred_pkt(1);
        tick();
        chk("t4_sat_send_ret", 64'(credits), 64'd128);
        din = cred_pkt(5);
        tick();
        din = '0;
        tick();
        chk("t4_sat_idle", 64'(credits), 64'd128);

        // 128-credit burst, then stall
        do_reset();
        win_cnt = 0;
        n_acc = 0;
        stream(250);
        chk("t2_packets", 64'(win_cnt), 64'd128);
        chk("t2_first_addr", 64'(win_first), 64'd0);
        chk("t2_last_addr", 64'(win_last), 64'd127);
        chk("t2_accepted", 64'(n_acc), 64'd132);
        chk("t2_tready", 64'(tready), 64'd0);
        chk("t2_credits", 64'(credits), 64'd0);
        chk("t2_idle", 64'(dout[48]), 64'd0);

        // Credit packet of 16 releases exactly 16 more packets
        win_cnt = 0;
        n_acc = 0;
        din = cred_pkt(16);
        stream(60);
        chk("t3_packets", 64'(win_cnt), 64'd16);
        chk("t3_first_addr", 64'(win_first), 64'd0);
        chk("t3_last_addr", 64'(win_last), 64'd15);
        chk("t3_accepted", 64'(n_acc), 64'd16);
        chk("t3_tready", 64'(tready), 64'd0);

        // At credits=1, send and return of 1 in the same cycle
        tvalid = 1'b0;
        din = cred_pkt(1);
        tick();
        din = cred_pkt(1);
        tick();
        din = '0;
        chk("t4_hold_one", 64'(credits), 64'd1);
        tick();
        chk("t4_drain_zero", 64'(credits), 64'd0);

        // Random traffic with random credit returns and ignored packets
        do_reset();
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            tick();
            tvalid = 1'($urandom % 2);
            tdata  = $urandom;
            r = int'($urandom % 16);
            if (r < 2)
                din = cred_pkt(int'($urandom_range(1, 8)));
            else if (r == 2)
                din = {1'b1, 5'($urandom), 4'($urandom_range(1, 15)), 7'($urandom), 32'($urandom)};
            else if (r == 3)
                din = {1'b0, 5'd0, 4'd0, 7'd0, 32'd8};
            else
                din = '0;
            if (tvalid && tready) n_acc++;
            cyc++;
        end
        chk("t5_words_accepted", 64'(n_acc), 64'd10000);

        // Reset mid-burst
        stream(20);
        do_reset();
        chk("t6_tready", 64'(tready), 64'd1);
        chk("t6_credits", 64'(credits), 64'd128);
        chk("t6_pkt_count", 64'(pkt_count), 64'd0);
        tvalid = 1'b1;
        tdata  = 32'h0000_600D;
        tick();
        tvalid = 1'b0;
        tick();
        tick();
        chk("t6_valid", 64'(dout[48]), 64'd1);
        chk("t6_addr", 64'(dout[38:32]), 64'd0);
        chk("t6_payload", 64'(dout[31:0]), 64'h600D);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
